// File: rtl/dline_pkg.sv
// Shared types and pointer/delay helpers for the dline_mc multi-lane delay buffer.
// The optional parity feature is enabled by defining DLINE_MC_PARITY_EN.
package dline_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    STEADY  = 2'd2
  } fill_state_t;

  // (a - b) mod m for 0 <= a < m and 1 <= b <= m, wrapped explicitly so any m works
  function automatic int wrap_sub(input int a, input int b, input int m);
    return (a >= b) ? (a - b) : (a + m - b);
  endfunction

  function automatic int clamp_delay(input int req, input int maxd);
    if (req < 1)
      return 1;
    else if (req > maxd)
      return maxd;
    else
      return req;
  endfunction

endpackage

// File: rtl/dline_mc_if.sv
// Control, data and status bundle of dline_mc; perr exists only with DLINE_MC_PARITY_EN.
interface dline_mc_if #(
  parameter int DEPTH = 8,
  parameter int BITS  = 64,
  parameter int LANES = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                   en;
  logic                   flush;
  logic                   cfg_we;
  logic [CW-1:0]          cfg_delay;
  logic [LANES*BITS-1:0]  d;
  logic [LANES*BITS-1:0]  q;
  logic                   q_valid;
  logic [CW-1:0]          fill_cnt;
  logic [CW-1:0]          delay_cur;
  logic [1:0]             state;
`ifdef DLINE_MC_PARITY_EN
  logic [LANES-1:0]       perr;

  modport master (
    output en, flush, cfg_we, cfg_delay, d,
    input  q, q_valid, fill_cnt, delay_cur, state, perr
  );
  modport slave (
    input  en, flush, cfg_we, cfg_delay, d,
    output q, q_valid, fill_cnt, delay_cur, state, perr
  );
`else
  modport master (
    output en, flush, cfg_we, cfg_delay, d,
    input  q, q_valid, fill_cnt, delay_cur, state
  );
  modport slave (
    input  en, flush, cfg_we, cfg_delay, d,
    output q, q_valid, fill_cnt, delay_cur, state
  );
`endif

endinterface

// File: rtl/dline_ram.sv
// DEPTH x W storage: one synchronous write port, asynchronous read, async clear on reset.
// Width W already includes parity bits when DLINE_MC_PARITY_EN is defined in the parent.
module dline_ram #(
  parameter int DEPTH = 8,
  parameter int W     = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dline_mc.sv
// Multi-lane runtime-programmable delay line: q is the d accepted delay_cur enables ago.
// Define DLINE_MC_PARITY_EN to store per-lane even parity and report sticky perr.
module dline_mc
  import dline_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int BITS      = 64,
  parameter int LANES     = 2,
  parameter int DEF_DELAY = DEPTH
) (
  input logic       clk,
  input logic       rst_n,
  dline_mc_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = LANES * BITS;
`ifdef DLINE_MC_PARITY_EN
  localparam int W  = DW + LANES;
`else
  localparam int W  = DW;
`endif

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] fill_cnt;
  logic [CW-1:0] fill_nxt;
  logic [CW-1:0] delay_cur;
  logic [CW-1:0] delay_nxt;
  fill_state_t   state;
  logic          clr;
  logic          q_valid;
  logic [W-1:0]  wdata;
  logic [W-1:0]  rdata;

  assign clr     = bus.flush | bus.cfg_we;
  assign rd_ptr  = AW'(wrap_sub(int'(wr_ptr), int'(delay_cur), DEPTH));
  assign q_valid = (fill_cnt >= delay_cur);

  // A flush (or cfg load) zeroes the count first, so a same-cycle enable counts as 1
  always_comb begin
    fill_nxt = clr ? '0 : fill_cnt;
    if (bus.en && (int'(fill_nxt) < DEPTH))
      fill_nxt = fill_nxt + CW'(1);
    delay_nxt = bus.cfg_we ? CW'(clamp_delay(int'(bus.cfg_delay), DEPTH)) : delay_cur;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      delay_cur <= CW'(DEF_DELAY);
      state     <= EMPTY;
    end else begin
      if (bus.en)
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      fill_cnt  <= fill_nxt;
      delay_cur <= delay_nxt;
      if (fill_nxt == '0)
        state <= EMPTY;
      else if (fill_nxt < delay_nxt)
        state <= FILLING;
      else
        state <= STEADY;
    end
  end

`ifdef DLINE_MC_PARITY_EN
  logic [LANES-1:0] perr;
  logic [LANES-1:0] par_bad;

  always_comb begin
    wdata          = '0;
    wdata[DW-1:0]  = bus.d;
    par_bad        = '0;
    for (int i = 0; i < LANES; i++) begin
      wdata[DW+i] = ^bus.d[i*BITS +: BITS];
      par_bad[i]  = rdata[DW+i] ^ (^rdata[i*BITS +: BITS]);
    end
  end

  // Errors are only meaningful on entries that are actually being presented as valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      perr <= '0;
    else if (clr)
      perr <= '0;
    else if (q_valid)
      perr <= perr | par_bad;
  end

  assign bus.perr = perr;
`else
  assign wdata = bus.d;
`endif

  dline_ram #(
    .DEPTH (DEPTH),
    .W     (W),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (bus.en),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign bus.q         = rdata[DW-1:0];
  assign bus.q_valid   = q_valid;
  assign bus.fill_cnt  = fill_cnt;
  assign bus.delay_cur = delay_cur;
  assign bus.state     = state;

endmodule

// File: tb/tb_dline_mc.sv
// Self-checking bench for dline_mc: table-driven vectors on a DEPTH=8 instance plus a DEPTH=5 wrap run.
// Parity corruption check is compiled only with DLINE_MC_PARITY_EN.
module tb_dline_mc;

  logic clk;
  logic rst_n;

  dline_mc_if #(.DEPTH(8), .BITS(64), .LANES(2)) bus ();
  dline_mc_if #(.DEPTH(5), .BITS(64), .LANES(2)) bus2 ();

  dline_mc #(.DEPTH(8), .BITS(64), .LANES(2), .DEF_DELAY(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  dline_mc #(.DEPTH(5), .BITS(64), .LANES(2), .DEF_DELAY(5)) u_dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       flush;
    logic       cfg_we;
    logic [3:0] cfg_delay;
    int         val;
    logic       ev;
    int         ef;
    logic [1:0] es;
    int         ed;
  } vec_t;

  vec_t         vecs[$];
  logic [127:0] sb[$];
  logic [127:0] sb5[$];
  int           nvec = 0;
  int           nerr = 0;

  function automatic logic [127:0] mkd(input int val);
    logic [63:0] v;
    v = 64'(val);
    return {v + 64'h100, v};
  endfunction

  function automatic void add(input logic en, input logic fl, input logic cw, input int cd,
                              input int val, input logic ev, input int ef, input int es,
                              input int ed);
    vec_t v;
    v.en = en; v.flush = fl; v.cfg_we = cw; v.cfg_delay = 4'(cd); v.val = val;
    v.ev = ev; v.ef = ef; v.es = 2'(es); v.ed = ed;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one vector on the DEPTH=8 instance, update the scoreboard, wait for the edge
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    bus.en        = v.en;
    bus.flush     = v.flush;
    bus.cfg_we    = v.cfg_we;
    bus.cfg_delay = v.cfg_delay;
    bus.d         = mkd(v.val);
    if (v.flush || v.cfg_we)
      sb.delete();
    if (v.en)
      sb.push_back(mkd(v.val));
    while (sb.size() > v.ed)
      void'(sb.pop_front());
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.en = 1'b0; bus.flush = 1'b0; bus.cfg_we = 1'b0; bus.cfg_delay = '0; bus.d = '0;
    bus2.en = 1'b0; bus2.flush = 1'b0; bus2.cfg_we = 1'b0; bus2.cfg_delay = '0; bus2.d = '0;

    // Phase A: default delay 8, wrap of the write pointer
    for (int i = 1; i <= 10; i++)
      add(1, 0, 0, 0, i, i >= 8, (i < 8) ? i : 8, (i >= 8) ? 2 : 1, 8);
    // Phase B: delay 3, enable gaps do not age data
    add(0, 0, 1, 3, 0, 0, 0, 0, 3);
    add(1, 0, 0, 0, 11, 0, 1, 1, 3);
    add(1, 0, 0, 0, 12, 0, 2, 1, 3);
    add(1, 0, 0, 0, 13, 1, 3, 2, 3);
    add(0, 0, 0, 0, 0, 1, 3, 2, 3);
    add(0, 0, 0, 0, 0, 1, 3, 2, 3);
    add(1, 0, 0, 0, 14, 1, 4, 2, 3);
    add(1, 0, 0, 0, 15, 1, 5, 2, 3);
    // Phase C: clamping and delay 1 with cfg+en in the same cycle
    add(0, 0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 15, 0, 0, 0, 0, 8);
    add(1, 0, 1, 1, 16, 1, 1, 2, 1);
    add(1, 0, 0, 0, 17, 1, 2, 2, 1);
    // Phase D: saturation at DEPTH, then flush with and without enable
    add(1, 0, 1, 8, 20, 0, 1, 1, 8);
    for (int i = 21; i <= 30; i++)
      add(1, 0, 0, 0, i, (i - 19) >= 8, ((i - 19) < 8) ? (i - 19) : 8, ((i - 19) >= 8) ? 2 : 1, 8);
    add(1, 1, 0, 0, 31, 0, 1, 1, 8);
    add(1, 0, 0, 0, 32, 0, 2, 1, 8);
    add(0, 1, 0, 0, 0, 0, 0, 0, 8);

    #12;
    checkOutput("reset q", bus.q, '0);
    checkOutput("reset q_valid", 128'(bus.q_valid), 128'(0));
    checkOutput("reset fill_cnt", 128'(bus.fill_cnt), 128'(0));
    checkOutput("reset delay_cur", 128'(bus.delay_cur), 128'(8));
    checkOutput("reset state", 128'(bus.state), 128'(0));
    checkOutput("reset delay_cur d5", 128'(bus2.delay_cur), 128'(5));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      applyStimulus(vecs[k]);
      checkOutput($sformatf("v%0d q_valid", k), 128'(bus.q_valid), 128'(vecs[k].ev));
      checkOutput($sformatf("v%0d fill_cnt", k), 128'(bus.fill_cnt), 128'(vecs[k].ef));
      checkOutput($sformatf("v%0d state", k), 128'(bus.state), 128'(vecs[k].es));
      checkOutput($sformatf("v%0d delay_cur", k), 128'(bus.delay_cur), 128'(vecs[k].ed));
      if (vecs[k].ev) begin
        if (sb.size() == 0) begin
          nvec++; nerr++;
          $display("[TB] FAIL v%0d q: scoreboard empty, nothing expected", k);
        end else begin
          checkOutput($sformatf("v%0d q", k), bus.q, sb[0]);
        end
      end
    end

    // Reset pulsed mid-stream with en asserted: outputs return to reset values at once
    add(1, 0, 0, 0, 33, 0, 1, 1, 8);
    applyStimulus(vecs[vecs.size()-1]);
    @(negedge clk);
    bus.en = 1'b1;
    bus.d  = mkd(34);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst q", bus.q, '0);
    checkOutput("midrst q_valid", 128'(bus.q_valid), 128'(0));
    checkOutput("midrst fill_cnt", 128'(bus.fill_cnt), 128'(0));
    checkOutput("midrst state", 128'(bus.state), 128'(0));
    checkOutput("midrst delay_cur", 128'(bus.delay_cur), 128'(8));
    @(posedge clk);
    #1;
    checkOutput("midrst held fill_cnt", 128'(bus.fill_cnt), 128'(0));
    @(negedge clk);
    bus.en = 1'b0;
    rst_n  = 1'b1;

`ifdef DLINE_MC_PARITY_EN
    // Corrupt lane 1 of the entry currently presented, then flush clears the sticky flag
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      bus.en = 1'b1;
      bus.d  = mkd(50 + i);
    end
    @(negedge clk);
    bus.en = 1'b0;
    u_dut.u_ram.mem[u_dut.wr_ptr][64] = ~u_dut.u_ram.mem[u_dut.wr_ptr][64];
    @(posedge clk);
    #1;
    checkOutput("perr set", 128'(bus.perr), 128'(2'b10));
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("perr cleared", 128'(bus.perr), 128'(0));
    @(negedge clk);
    bus.flush = 1'b0;
`endif

    // DEPTH=5 instance: non-power-of-two wrap with D = DEPTH
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bus2.en = 1'b1;
      bus2.d  = mkd(9 + k);
      sb5.push_back(mkd(9 + k));
      while (sb5.size() > 5)
        void'(sb5.pop_front());
      @(posedge clk);
      #1;
      checkOutput($sformatf("d5 k%0d q_valid", k), 128'(bus2.q_valid), 128'(k >= 5));
      checkOutput($sformatf("d5 k%0d fill_cnt", k), 128'(bus2.fill_cnt), 128'((k < 5) ? k : 5));
      if (k >= 5)
        checkOutput($sformatf("d5 k%0d q", k), bus2.q, sb5[0]);
    end
    @(negedge clk);
    bus2.en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
